// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// image-format constants and the byte-lane insert helper.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_HDR_LO = 3'd0,
      ST_HDR_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   function automatic logic [31:0] insert_byte(
      input logic [31:0] word,
      input logic [1:0]  lane,
      input logic [7:0]  data
   );
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = data;
         2'd1:    res[15:8]  = data;
         2'd2:    res[23:16] = data;
         default: res[31:24] = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Byte-to-word packer: collects little-endian bytes into a 32-bit word and
// pulses word_valid for one cycle after the last lane is filled.
module imem_boot_loader_packer
   import imem_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [1:0]  lane,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  lane_r;
   logic [31:0] acc_r;
   logic [31:0] word_r;
   logic        word_valid_r;

   // Lane counter, partial accumulator and completed-word holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_r       <= 2'd0;
         acc_r        <= 32'd0;
         word_r       <= 32'd0;
         word_valid_r <= 1'b0;
      end else begin
         word_valid_r <= 1'b0;
         if (clr) begin
            lane_r <= 2'd0;
            acc_r  <= 32'd0;
         end else if (byte_en) begin
            if (lane_r == LAST_LANE) begin
               // word_r only moves on completion so it holds outside the write
               word_r       <= insert_byte(acc_r, lane_r, byte_data);
               word_valid_r <= 1'b1;
               lane_r       <= 2'd0;
               acc_r        <= 32'd0;
            end else begin
               acc_r  <= insert_byte(acc_r, lane_r, byte_data);
               lane_r <= lane_r + 2'd1;
            end
         end
      end
   end

   assign lane       = lane_r;
   assign word       = word_r;
   assign word_valid = word_valid_r;

endmodule

// File: rtl/imem_boot_loader.sv
// Synthesizable instruction-memory boot loader: parses a counted byte image,
// writes it word by word and holds the core in reset until it is complete.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int               MAX_WORDS = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] ZERO_N    = {CNT_W{1'b0}};
   localparam logic [1:0]       LAST_LANE = 2'(BYTES_PER_WORD - 1);

   state_t                 state_r;
   logic [CNT_W-1:0]       count_r;
   logic [ADDR_W:0]        words_loaded_r;
   logic [ADDR_W-1:0]      addr_r;
   logic                   core_rst_r;
   logic                   done_r;
   logic                   err_r;
   logic                   ready_s;
   logic                   xfer_s;
   logic [HDR_BYTES*8-1:0] n_full_s;
   logic [CNT_W-1:0]       loaded_next_s;
   logic [1:0]             lane_s;
   logic                   word_valid_s;
   logic [31:0]            word_s;

   // Byte acceptance depends only on state (and reset), never on in_valid.
   always_comb begin
      ready_s = 1'b0;
      if (!rst) begin
         ready_s = 1'b0;
      end else begin
         case (state_r)
            ST_HDR_LO, ST_HDR_HI, ST_DATA: ready_s = 1'b1;
            default:                       ready_s = 1'b0;
         endcase
      end
   end

   assign xfer_s        = in_valid && ready_s;
   assign n_full_s      = {in_data, count_r[7:0]};
   assign loaded_next_s = CNT_W'(words_loaded_r) + CNT_W'(1);

   imem_boot_loader_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        ((state_r == ST_HDR_HI) && xfer_s),
      .byte_en    ((state_r == ST_DATA) && xfer_s),
      .byte_data  (in_data),
      .lane       (lane_s),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   // Loader FSM with header parsing, word counting and registered status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_HDR_LO;
         count_r        <= ZERO_N;
         words_loaded_r <= {(ADDR_W+1){1'b0}};
         addr_r         <= {ADDR_W{1'b0}};
         core_rst_r     <= 1'b1;
         done_r         <= 1'b0;
         err_r          <= 1'b0;
      end else begin
         case (state_r)
            ST_HDR_LO: begin
               if (xfer_s) begin
                  count_r[7:0] <= in_data;
                  state_r      <= ST_HDR_HI;
               end
            end
            ST_HDR_HI: begin
               if (xfer_s) begin
                  count_r <= n_full_s;
                  if (n_full_s == ZERO_N) begin
                     state_r    <= ST_DONE;
                     core_rst_r <= 1'b0;
                     done_r     <= 1'b1;
                  end else if (n_full_s > MAX_N) begin
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer_s && (lane_s == LAST_LANE)) begin
                  addr_r  <= words_loaded_r[ADDR_W-1:0];
                  state_r <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               words_loaded_r <= words_loaded_r + (ADDR_W+1)'(1);
               if (loaded_next_s == count_r) begin
                  state_r    <= ST_DONE;
                  core_rst_r <= 1'b0;
                  done_r     <= 1'b1;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_DONE, ST_ERR: begin
               if (start) begin
                  state_r        <= ST_HDR_LO;
                  words_loaded_r <= {(ADDR_W+1){1'b0}};
                  core_rst_r     <= 1'b1;
                  done_r         <= 1'b0;
                  err_r          <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_HDR_LO;
               core_rst_r <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready     = ready_s;
   assign imem_we      = word_valid_s;
   assign imem_addr    = addr_r;
   assign imem_wdata   = word_s;
   assign core_rst     = core_rst_r;
   assign done         = done_r;
   assign err          = err_r;
   assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as images
// are driven and popped when the loader strobes instruction memory.
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int n_checks = 0;
   int n_fail   = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [ADDR_W+31:0] exp_e;
   logic [31:0]        img [256];

   imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (imem_we || done)
            check_eq("ready_blocked", 64'(in_ready), 64'd0);
         if (imem_we) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_we", 64'(imem_we), 64'd0);
            end else begin
               exp_e = exp_q.pop_front();
               check_eq("we_addr",  64'(imem_addr),    64'(exp_e[ADDR_W+31:32]));
               check_eq("we_data",  64'(imem_wdata),   64'(exp_e[31:0]));
               check_eq("we_count", 64'(words_loaded), 64'(exp_e[ADDR_W+31:32]));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
      int unsigned gap;
      int t;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("byte_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load_image(input int n, input int unsigned gap);
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
      if (n == 0) begin
         check_eq("zero_done",     64'(done),     64'd1);
         check_eq("zero_core_rst", 64'(core_rst), 64'd0);
      end else begin
         for (int w = 0; w < n; w++) begin
            exp_q.push_back({ADDR_W'(w), img[w]});
            for (int k = 0; k < 4; k++)
               send_byte(img[w][8*k +: 8], gap);
         end
         check_eq("last_we",       64'(imem_we),  64'd1);
         check_eq("core_rst_held", 64'(core_rst), 64'd1);
         @(posedge clk);
         #1;
         check_eq("done",         64'(done),         64'd1);
         check_eq("core_release", 64'(core_rst),     64'd0);
         check_eq("words_loaded", 64'(words_loaded), 64'(n));
      end
      check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_ready"},    64'(in_ready),     64'd0);
      check_eq({tag, "_we"},       64'(imem_we),      64'd0);
      check_eq({tag, "_addr"},     64'(imem_addr),    64'd0);
      check_eq({tag, "_wdata"},    64'(imem_wdata),   64'd0);
      check_eq({tag, "_core_rst"}, 64'(core_rst),     64'd1);
      check_eq({tag, "_done"},     64'(done),         64'd0);
      check_eq({tag, "_err"},      64'(err),          64'd0);
      check_eq({tag, "_count"},    64'(words_loaded), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      @(negedge clk);
      rst = 1'b1;

      // basic two-word load, back to back
      img[0] = 32'h00100513;
      img[1] = 32'h00200593;
      load_image(2, 0);
      pulse_start();
      check_eq("restart_core_rst", 64'(core_rst),     64'd1);
      check_eq("restart_done",     64'(done),         64'd0);
      check_eq("restart_count",    64'(words_loaded), 64'd0);

      // same image with random source gaps
      load_image(2, 5);
      pulse_start();

      // zero-length image
      load_image(0, 0);
      pulse_start();

      // oversize header N=257
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check_eq("ovr_err",      64'(err),      64'd1);
      check_eq("ovr_core_rst", 64'(core_rst), 64'd1);
      check_eq("ovr_ready",    64'(in_ready), 64'd0);
      check_eq("ovr_done",     64'(done),     64'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("ovr_err_hold", 64'(err), 64'd1);
      pulse_start();
      check_eq("ovr_clr_err",  64'(err),      64'd0);
      check_eq("ovr_hdr_lo",   64'(in_ready), 64'd1);

      // reset during third byte of the second word
      img[0] = 32'h44332211;
      exp_q.push_back({ADDR_W'(0), img[0]});
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h77;
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals("async");
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      img[0] = 32'hDDCCBBAA;
      load_image(1, 0);
      pulse_start();

      // full capacity, then reload
      for (int i = 0; i < 256; i++)
         img[i] = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      load_image(256, 0);
      pulse_start();
      check_eq("reload_core_rst", 64'(core_rst),     64'd1);
      check_eq("reload_done",     64'(done),         64'd0);
      check_eq("reload_count",    64'(words_loaded), 64'd0);
      img[0] = 32'hCAFEF00D;
      load_image(1, 0);

      repeat (2) @(posedge clk);
      check_eq("sb_final_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
